// File: rtl/gpr_file_if.sv
//------------------------------------------------------------------------------
// Module      : gpr_file_if
// Description : Decode/writeback bundle for the general-purpose register file.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gpr_file_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 2
);
    logic                             init_busy;
    logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr;
    logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata;
    logic [NUM_RPORTS-1:0]            rpend;
    logic                             wen;
    logic [ADDR_WIDTH-1:0]            waddr;
    logic [DATA_WIDTH-1:0]            wdata;
    logic                             alloc_en;
    logic [ADDR_WIDTH-1:0]            alloc_addr;

    modport master (
        input  init_busy, rdata, rpend,
        output raddr, wen, waddr, wdata, alloc_en, alloc_addr
    );

    modport slave (
        output init_busy, rdata, rpend,
        input  raddr, wen, waddr, wdata, alloc_en, alloc_addr
    );
endinterface

`default_nettype wire

// File: rtl/gpr_file.sv
//------------------------------------------------------------------------------
// Module      : gpr_file
// Description : Multi-port register file with write-pending scoreboard and
//               self-clearing reset sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gpr_file #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 2,
    parameter bit BYPASS     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    gpr_file_if.slave  bus
);

    localparam int                    c_DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = '1;
    localparam logic [0:0]            c_CLEAR    = 1'b0;
    localparam logic [0:0]            c_READY    = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic                  w_init_busy;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0] r_rf [c_DEPTH];
    logic [c_DEPTH-1:0]    r_pend;
    logic                  w_wr;
    logic                  w_alloc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_CLEAR: if (r_idx == c_LAST_IDX) w_state_next = c_READY;
            default: w_state_next = r_state;
        endcase
    end

    always_comb begin
        w_init_busy = (r_state == c_CLEAR);
    end

    assign bus.init_busy = w_init_busy;
    assign w_wr          = bus.wen && (bus.waddr != '0);
    assign w_alloc       = bus.alloc_en && (bus.alloc_addr != '0);

    // Allocate is applied after the write so a new producer supersedes a retiring one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_pend <= '0;
        end else if (w_init_busy) begin
            r_rf[r_idx] <= '0;
            r_idx       <= r_idx + ADDR_WIDTH'(1);
        end else begin
            if (w_wr) begin
                r_rf[bus.waddr]   <= bus.wdata;
                r_pend[bus.waddr] <= 1'b0;
            end
            if (w_alloc) begin
                r_pend[bus.alloc_addr] <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_rport
            logic [ADDR_WIDTH-1:0] w_addr;
            logic                  w_hit;
            logic [DATA_WIDTH-1:0] w_rd;
            logic                  w_rp;

            assign w_addr = bus.raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_hit  = BYPASS && bus.wen && (bus.waddr == w_addr);

            always_comb begin
                w_rd = r_rf[w_addr];
                w_rp = r_pend[w_addr];
                if (w_hit) begin
                    w_rd = bus.wdata;
                    w_rp = 1'b0;
                end
                if (w_init_busy || (w_addr == '0)) begin
                    w_rd = '0;
                    w_rp = 1'b0;
                end
            end

            assign bus.rdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd;
            assign bus.rpend[gi]                          = w_rp;
        end
    endgenerate

endmodule

`default_nettype wire
